// File: rtl/apb_pkg.sv
// Shared APB types and bus widths for the APB completer and requester.
package apb_pkg;

  typedef enum logic {IDLE, ACCESS} apb_state_e;

  localparam int unsigned APB_DW = 32;
  localparam int unsigned APB_AW = 32;

  localparam logic [APB_DW-1:0] RD_ERR_DATA = 32'h0;

endpackage : apb_pkg

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory with programmable wait states.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        wait_cfg_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [APB_AW-1:0] paddr_i,
  input  logic              pwrite_i,
  input  logic [APB_DW-1:0] pwdata_i,
  output logic              pready_o,
  output logic [APB_DW-1:0] prdata_o,
  output logic              pslverr_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [APB_AW-1:0] ADDR_LIMIT = APB_AW'(DEPTH * 4);

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  index_q;
  logic              write_q;
  logic [APB_DW-1:0] wdata_q;
  logic              err_q;
  logic [APB_DW-1:0] prdata_q;
  logic [APB_DW-1:0] mem [DEPTH];

  logic              setup_c;
  logic              err_c;
  logic [IDX_W-1:0]  index_c;
  logic              ready_c;
  logic              complete_c;
  logic              commit_c;

  assign setup_c    = psel_i & ~penable_i;
  assign err_c      = (paddr_i >= ADDR_LIMIT);
  assign index_c    = paddr_i[2 +: IDX_W];
  // Ready depends only on registered state, so there is no bus-input-to-pready path.
  assign ready_c    = (state_q == ACCESS) && (cnt_q == '0);
  assign complete_c = psel_i & penable_i & ready_c;
  assign commit_c   = complete_c & write_q & ~err_q;

  assign pready_o  = ready_c;
  assign pslverr_o = ready_c & err_q;
  assign prdata_o  = prdata_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (setup_c) state_d = ACCESS;
      end
      ACCESS: begin
        if (!psel_i || complete_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Transfer capture, wait counter and read-data register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      index_q  <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (setup_c) begin
          cnt_q   <= wait_cfg_i;
          index_q <= index_c;
          write_q <= pwrite_i;
          wdata_q <= pwdata_i;
          err_q   <= err_c;
          if (!pwrite_i) prdata_q <= err_c ? RD_ERR_DATA : mem[index_c];
        end
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Memory array; only a completed, non-error write commits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit_c) begin
      mem[index_q] <= wdata_q;
    end
  end

endmodule : apb_slave_mem

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: stimulus queues expected responses, a monitor checks completions.
module tb_apb_slave_mem;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  wait_cfg;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned acc_cnt  = 0;

  apb_slave_mem #(.DEPTH(16)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .wait_cfg_i (wait_cfg),
    .psel_i     (psel),
    .penable_i  (penable),
    .paddr_i    (paddr),
    .pwrite_i   (pwrite),
    .pwdata_i   (pwdata),
    .pready_o   (pready),
    .prdata_o   (prdata),
    .pslverr_o  (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: counts access cycles and checks each completion against the scoreboard
  always @(negedge clk) begin
    if (rst_n && psel && penable) begin
      acc_cnt++;
      if (pready) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", 32'(acc_cnt), 32'(e.lat));
          chk("pslverr", {31'd0, pslverr}, {31'd0, e.err});
          if (e.is_read) chk("prdata", prdata, e.rdata);
        end
        acc_cnt = 0;
      end
    end else begin
      acc_cnt = 0;
    end
  end

  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                      input logic [3:0] w, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    e.is_read = !wr;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.lat     = 32'(w) + 1;
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data; wait_cfg = w;
    @(posedge clk); #1;
    penable = 1'b1;
    // Captured values must be used; perturb the bus during the access phase
    paddr  = 32'hFFFF_FFF0;
    pwdata = 32'hDEAD_BEEF;
    wait_cfg = 4'hF;
    for (int i = 0; i < 40 && !pready; i++) begin
      @(posedge clk); #1;
    end
    chk("ready_timeout", {31'd0, pready}, 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0; wait_cfg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", {31'd0, pready}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("stray_penable_ignored", {31'd0, pready}, 32'd0);
    penable = 1'b0;
    @(posedge clk); #1;

    xfer(32'h0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);

    xfer(32'h8, 1'b1, 32'hA5A5_1234, 4'd3, 32'h0, 1'b0);
    xfer(32'h8, 1'b0, 32'h0, 4'd0, 32'hA5A5_1234, 1'b0);
    xfer(32'hB, 1'b0, 32'h0, 4'd1, 32'hA5A5_1234, 1'b0);

    xfer(32'h40, 1'b1, 32'h5555_AAAA, 4'd2, 32'h0, 1'b1);
    chk("err_write_keeps_prdata", prdata, 32'hA5A5_1234);
    xfer(32'h40, 1'b0, 32'h0, 4'd0, 32'h0, 1'b1);
    xfer(32'h0, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);

    for (int i = 0; i < 16; i++) xfer(32'(i * 4), 1'b1, 32'(i * 32'h11), 4'd0, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) xfer(32'(i * 4), 1'b0, 32'h0, 4'd0, 32'(i * 32'h11), 1'b0);

    // Abort a write after two access cycles
    psel = 1'b1; penable = 1'b0; paddr = 32'h4; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; wait_cfg = 4'd5;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("abort_wait1", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    chk("abort_wait2", {31'd0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle", {31'd0, pready}, 32'd0);
    xfer(32'h4, 1'b0, 32'h0, 4'd2, 32'h11, 1'b0);
    xfer(32'h3C, 1'b0, 32'h0, 4'd0, 32'hFF, 1'b0);

    // Asynchronous reset in the middle of a write access
    psel = 1'b1; penable = 1'b0; paddr = 32'h3C; pwrite = 1'b1; pwdata = 32'h1234_5678; wait_cfg = 4'd3;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pready", {31'd0, pready}, 32'd0);
    chk("async_rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("async_rst_prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(32'h3C, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);
    xfer(32'h8, 1'b0, 32'h0, 4'd1, 32'h0, 1'b0);
    xfer(32'h4, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_apb_slave_mem
